imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_imm_encoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Merges an immediate value (or byte offset) into a 32-bit instruction word.
// Four field formats are supported:
//   00 uimm12       : unsigned 12-bit value        -> bits [21:10]
//   01 simm9        : signed 9-bit value           -> bits [20:12]
//   10 branch26     : signed word offset, 26 bits  -> bits [25:0]  (imm[27:2])
//   11 condbranch19 : signed word offset, 19 bits  -> bits [23:5]  (imm[20:2])
//
// Two-stage valid/ready pipeline:
//   S1 captures the request, checks range/alignment and pre-positions the field.
//   S2 merges the field into the base word and drives the outputs.
// A request whose immediate does not fit is flagged with out_err and its field
// bits are zeroed in out_inst. err_cnt counts erroring results handed off.
//
// Ports
//   clk        : clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   in_valid   : request present
//   in_ready   : request accepted this cycle when in_valid is high
//   in_fmt     : field format select (see above)
//   in_imm     : 64-bit immediate / byte offset
//   in_base    : instruction word; field bits are don't-care
//   out_valid  : encoded result present
//   out_ready  : consumer takes the result this cycle
//   out_inst   : encoded instruction word
//   out_err    : immediate not representable in the selected format
//   clr_cnt    : synchronous clear of err_cnt
//   err_cnt    : saturating count of erroring results handed off
// -----------------------------------------------------------------------------
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic [63:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    FMT_U12  = 2'b00,
    FMT_S9   = 2'b01,
    FMT_B26  = 2'b10,
    FMT_CB19 = 2'b11
  } fmt_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Bit positions occupied by each format's field inside the instruction word.
  function automatic logic [31:0] field_mask(input fmt_e f);
    logic [31:0] m;
    m = 32'h0000_0000;
    case (f)
      FMT_U12:  m = 32'h003F_FC00;  // [21:10]
      FMT_S9:   m = 32'h001F_F000;  // [20:12]
      FMT_B26:  m = 32'h03FF_FFFF;  // [25:0]
      FMT_CB19: m = 32'h00FF_FFE0;  // [23:5]
      default:  m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic        s1_valid;
  fmt_e        s1_fmt;
  logic [31:0] s1_base;
  logic [31:0] s1_field;   // already positioned, zero when s1_err
  logic        s1_err;

  logic        s2_valid;

  // Handshake decisions
  logic in_xfer;
  logic s2_load;
  logic out_xfer;

  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_valid && out_ready;

  assign out_valid = s2_valid;

  // ---------------------------------------------------------------------------
  // S1 capture: range / alignment check and field positioning
  // ---------------------------------------------------------------------------
  fmt_e        cap_fmt;
  logic        cap_ok;
  logic [31:0] cap_field;

  assign cap_fmt = fmt_e'(in_fmt);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    cap_ok    = 1'b0;
    cap_field = 32'h0000_0000;
    case (cap_fmt)
      FMT_U12: begin
        cap_ok    = (in_imm[63:12] == 52'd0);
        cap_field = {10'd0, in_imm[11:0], 10'd0};
      end
      FMT_S9: begin
        // All bits above the field must replicate the field's sign bit.
        cap_ok    = (in_imm[63:8] == {56{in_imm[8]}});
        cap_field = {11'd0, in_imm[8:0], 12'd0};
      end
      FMT_B26: begin
        cap_ok    = (in_imm[1:0] == 2'b00) &&
                    (in_imm[63:27] == {37{in_imm[27]}});
        cap_field = {6'd0, in_imm[27:2]};
      end
      FMT_CB19: begin
        cap_ok    = (in_imm[1:0] == 2'b00) &&
                    (in_imm[63:20] == {44{in_imm[20]}});
        cap_field = {8'd0, in_imm[20:2], 5'd0};
      end
      default: begin
        cap_ok    = 1'b0;
        cap_field = 32'h0000_0000;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= FMT_U12;
      s1_base  <= 32'h0000_0000;
      s1_field <= 32'h0000_0000;
      s1_err   <= 1'b0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_fmt   <= cap_fmt;
        s1_base  <= in_base;
        // An unrepresentable immediate contributes nothing, so the merge in S2
        // leaves the field bits cleared.
        s1_field <= cap_ok ? cap_field : 32'h0000_0000;
        s1_err   <= !cap_ok;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: merge field into base word (replace, not OR) and hold for the consumer
  // ---------------------------------------------------------------------------
  logic [31:0] merge_inst;

  assign merge_inst = (s1_base & ~field_mask(s1_fmt)) | s1_field;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_inst <= 32'h0000_0000;
      out_err  <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        out_inst <= merge_inst;
        out_err  <= s1_err;
      end else if (out_xfer) begin
        // Data is left in place; only the valid flag drops.
        s2_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter: counts erroring hand-offs, saturates at all-ones.
  // A clear coinciding with an erroring hand-off leaves a count of one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= (out_xfer && out_err) ? CNT_ONE : '0;
    end else if (out_xfer && out_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//
// Self-checking bench for imm_encoder. Requests are driven shortly after the
// rising edge; every accepted request pushes its model-computed result onto a
// scoreboard queue, and a negedge monitor pops and compares each hand-off.
// The error counter is modelled alongside the scoreboard. A narrow counter
// (CNT_W = 4) keeps the saturation case short.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_fmt;
  logic [63:0]      in_imm;
  logic [31:0]      in_base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic             clr_cnt;
  logic [CNT_W-1:0] err_cnt;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .clr_cnt   (clr_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoder built directly from the format table.
  function automatic exp_t model(input logic [1:0] f, input logic [63:0] imm,
                                 input logic [31:0] base);
    exp_t        r;
    logic        ok;
    logic [31:0] mask;
    logic [31:0] fld;
    ok = 1'b0; mask = '0; fld = '0;
    case (f)
      2'b00: begin
        ok   = (imm[63:12] == 52'd0);
        mask = 32'h003F_FC00;
        fld  = 32'(imm[11:0]) << 10;
      end
      2'b01: begin
        ok   = (imm[63:8] == {56{imm[8]}});
        mask = 32'h001F_F000;
        fld  = 32'(imm[8:0]) << 12;
      end
      2'b10: begin
        ok   = (imm[1:0] == 2'b00) && (imm[63:27] == {37{imm[27]}});
        mask = 32'h03FF_FFFF;
        fld  = 32'(imm[27:2]);
      end
      default: begin
        ok   = (imm[1:0] == 2'b00) && (imm[63:20] == {44{imm[20]}});
        mask = 32'h00FF_FFE0;
        fld  = 32'(imm[20:2]) << 5;
      end
    endcase
    r.inst = (base & ~mask) | (ok ? fld : 32'h0);
    r.err  = !ok;
    return r;
  endfunction

  // Monitor: compare hand-offs and track the expected counter.
  exp_t mon_e;
  logic mon_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      mon_err = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", out_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("inst", out_inst, mon_e.inst);
          check("err", out_err, mon_e.err);
          mon_err = mon_e.err;
        end
      end
      if (clr_cnt)
        exp_cnt = mon_err ? CNT_W'(1) : '0;
      else if (mon_err && exp_cnt != '1)
        exp_cnt = exp_cnt + CNT_W'(1);
    end
  end

  // Drive one request; called and returns at posedge+1.
  task automatic send(input logic [1:0] f, input logic [63:0] imm,
                      input logic [31:0] base);
    int  n;
    bit  done;
    n = 0; done = 0;
    in_valid = 1'b1; in_fmt = f; in_imm = imm; in_base = base;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(f, imm, base));
        done = 1;
      end else if (n > 200) begin
        check("send_timeout", in_ready, 1'b1);
        done = 1;
      end
      n++;
      @(posedge clk); #1;
      if (!done && rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
  endtask

  // Let everything outstanding leave the pipeline.
  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  logic [31:0] r;
  logic [63:0] imm;
  time         t0;
  int          n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_fmt = '0; in_imm = '0; in_base = '0;
    out_ready = 1'b0; clr_cnt = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 1'b1);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Known answer plus two-cycle latency.
    out_ready = 1'b1;
    send(2'b00, 64'hABC, 32'h9100_0000);
    check("lat_n1", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_n2", out_valid, 1'b1);
    check("ka_u12", out_inst, 32'h912A_F000);
    drain();

    // Signed field and negative branch offset.
    send(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 32'hF840_0000);
    drain();
    check("ka_s9", out_inst, 32'hF85F_F000);
    send(2'b10, 64'hFFFF_FFFF_FFFF_FFF8, 32'h1400_0000);
    drain();
    check("ka_b26", out_inst, 32'h17FF_FFFE);

    // Misaligned and out-of-range: counter 0 -> 2.
    check("cnt_before_err", err_cnt, 0);
    send(2'b10, 64'h6, 32'h5400_0000);
    send(2'b11, 64'h10_0000, 32'h5400_0000);
    drain();
    check("ka_err_inst", out_inst, 32'h5400_0000);
    check("cnt_after_err", err_cnt, 2);

    // Range boundaries in every format.
    send(2'b00, 64'hFFF, $urandom);
    send(2'b00, 64'h1000, $urandom);
    send(2'b01, 64'hFF, $urandom);
    send(2'b01, 64'h100, $urandom);
    send(2'b01, 64'hFFFF_FFFF_FFFF_FF00, $urandom);
    send(2'b01, 64'hFFFF_FFFF_FFFF_FEFF, $urandom);
    send(2'b10, 64'h07FF_FFFC, $urandom);
    send(2'b10, 64'h0800_0000, $urandom);
    send(2'b10, 64'hFFFF_FFFF_F800_0000, $urandom);
    send(2'b11, 64'h000F_FFFC, $urandom);
    send(2'b11, 64'hFFFF_FFFF_FFF0_0000, $urandom);
    send(2'b11, 64'hFFFF_FFFF_FFEF_FFFC, $urandom);
    send(2'b11, 64'h2, $urandom);
    drain();

    // Backpressure: two accepts fill the pipe, then in_ready drops.
    out_ready = 1'b0;
    send(2'b00, 64'h123, 32'hAAAA_AAAA);
    send(2'b01, 64'h7F, 32'h5555_5555);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    check("bp_hold_inst", out_inst, model(2'b00, 64'h123, 32'hAAAA_AAAA).inst);
    out_ready = 1'b1;
    send(2'b10, 64'h400, 32'h0F0F_0F0F);
    send(2'b11, 64'h8, 32'hFFFF_FFFF);
    drain();

    // Full throughput with no stall.
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 4; i++) send(2'(i), 64'(i * 4), 32'h1234_5678);
    check("thruput", 64'($time - t0), 64'd40);
    drain();

    // Random traffic with random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       imm = 64'(r & 32'h0000_1FFF);
        1:       imm = {{44{1'b1}}, r[19:0]};
        2:       imm = {36'd0, r[27:0]};
        default: imm = {$urandom, r};
      endcase
      send(2'($urandom_range(0, 3)), imm, $urandom);
    end
    rnd_ready = 1'b0;
    drain();
    check("cnt_random", err_cnt, exp_cnt);

    // Plain clear, then saturation.
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("cnt_clr", err_cnt, 0);
    for (int i = 0; i < 18; i++) send(2'b00, 64'h1000, $urandom);
    drain();
    check("cnt_sat", err_cnt, 4'hF);

    // Clear coinciding with an erroring hand-off.
    out_ready = 1'b0;
    send(2'b00, 64'h1000, 32'h0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("clr_wait", out_valid, 1'b1);
    clr_cnt = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("cnt_clr_err", err_cnt, 1);
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(2'b01, 64'h1FF_FFFF, 32'h0);
    send(2'b00, 64'h1, 32'h0);
    check("pre_rst_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_cnt", err_cnt, 0);
    check("rst_mid_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    #20 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_stale", out_valid, 1'b0);
    end
    send(2'b11, 64'hFFFF_FFFF_FFFF_FFFC, 32'h5400_0001);
    @(posedge clk); #1;
    check("post_rst_valid", out_valid, 1'b1);
    drain();
    check("post_rst_cnt", err_cnt, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
